sgd_x_host_wr_burst: RTL and testbench

- Sits directly downstream of the x-model write-back stage.
- Accepts a write command (start pulse, host byte address, byte length) and the matching 512-bit stream of updated-model words.
- Buffers the words in an internal FIFO and back-pressures the producer with almost_full.
- Splits the transfer into host-memory write bursts that never cross a MAX_BURST_BYTES-aligned boundary. Each burst is issued only when its full payload is already buffered, so the write bus never stalls mid-burst for lack of data.

---
 rtl/sgd_x_host_wr_burst_if.sv | 53 +++++
 rtl/sgd_x_host_wr_burst.sv | 246 ++++++++++++++++++++++++
 tb/tb_sgd_x_host_wr_burst.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sgd_x_host_wr_burst_if.sv
// Bundle of the producer-side stream/command signals and the host-memory
// write bus used by sgd_x_host_wr_burst. The master modport is the burst
// engine's view; the slave modport is the view of whatever surrounds it
// (producer plus memory write channel).
interface sgd_x_host_wr_burst_if #(
    parameter int DATA_WIDTH = 512
);
    // Command and data stream from the x-model write-back stage
    logic                  x_data_send_back_start;
    logic [63:0]           x_data_send_back_addr;
    logic [31:0]           x_data_send_back_length;
    logic [DATA_WIDTH-1:0] x_data_out;
    logic                  x_data_out_valid;
    logic                  x_data_out_almost_full;

    // Host-memory write bus
    logic                  wr_cmd_valid;
    logic                  wr_cmd_ready;
    logic [63:0]           wr_cmd_addr;
    logic [31:0]           wr_cmd_len;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_data_valid;
    logic                  wr_data_ready;
    logic                  wr_data_last;

    // Status
    logic                  wr_busy;
    logic                  wr_done;
    logic [1:0]            wr_error;
    logic [31:0]           state_counters_x_host_wr;

    modport master (
        input  x_data_send_back_start, x_data_send_back_addr, x_data_send_back_length,
        input  x_data_out, x_data_out_valid,
        output x_data_out_almost_full,
        output wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
        input  wr_cmd_ready,
        output wr_data, wr_data_valid, wr_data_last,
        input  wr_data_ready,
        output wr_busy, wr_done, wr_error, state_counters_x_host_wr
    );

    modport slave (
        output x_data_send_back_start, x_data_send_back_addr, x_data_send_back_length,
        output x_data_out, x_data_out_valid,
        input  x_data_out_almost_full,
        input  wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
        output wr_cmd_ready,
        input  wr_data, wr_data_valid, wr_data_last,
        output wr_data_ready,
        input  wr_busy, wr_done, wr_error, state_counters_x_host_wr
    );
endinterface

// File: rtl/sgd_x_host_wr_burst.sv
// Host write-burst engine for updated x-model words.
// Buffers the producer stream in a first-word-fall-through FIFO and splits
// each write command into bursts that never cross a MAX_BURST_BYTES-aligned
// boundary. A burst command is only issued once its whole payload is
// buffered, so the data phase never starves mid-burst.
module sgd_x_host_wr_burst #(
    parameter int DATA_WIDTH         = 512,
    parameter int FIFO_DEPTH_BITS    = 7,
    parameter int ALMOST_FULL_MARGIN = 8,
    parameter int MAX_BURST_BYTES    = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sgd_x_host_wr_burst_if.master      bus
);
    localparam int DEPTH      = 1 << FIFO_DEPTH_BITS;
    localparam int CW         = FIFO_DEPTH_BITS + 1;          // count needs to reach DEPTH
    localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int BOFF_W     = $clog2(MAX_BURST_BYTES);

    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL_C  = CW'(DEPTH - ALMOST_FULL_MARGIN);
    localparam logic [CW-1:0] ONE_BEAT_C  = CW'(1);
    localparam logic [32:0]   MAX_BURST_C = 33'(MAX_BURST_BYTES);
    localparam logic [32:0]   BEAT_MASK_C = 33'((DATA_WIDTH / 8) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]      mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [CW-1:0]              count;
    logic                       almost_full_q;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign push       = bus.x_data_out_valid && !fifo_full;

    // Storage write port.
    // NOTE: the data array is deliberately left out of reset; emptiness is
    // tracked by the pointers and count, and an unreset array maps onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.x_data_out;
        end
    end

    // Pointers, occupancy and the registered almost-full flag.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            almost_full_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            almost_full_q <= (count >= AF_LEVEL_C);
        end
    end

    // ------------------------------------------------------------------
    // Command sequencing
    // ------------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    logic [63:0]   addr_q;
    logic [32:0]   remaining_q;      // rounded length may reach 2^32
    logic [31:0]   burst_q;
    logic [CW-1:0] beats_q;

    logic [32:0]   rounded_len;
    logic [32:0]   room;
    logic [31:0]   burst_bytes;
    logic [CW-1:0] burst_words;

    logic          load_cmd;
    logic          cmd_accept;
    logic          burst_end;
    logic          cmd_valid;
    logic          data_valid;
    logic          data_last;
    logic          busy;
    logic          done;

    // Round the requested length up to whole beats.
    assign rounded_len = ({1'b0, bus.x_data_send_back_length} + BEAT_MASK_C) & ~BEAT_MASK_C;

    // Current burst: bounded by what is left and by the distance to the
    // next MAX_BURST_BYTES boundary.
    always_comb begin
        room        = MAX_BURST_C - {{(33 - BOFF_W){1'b0}}, addr_q[BOFF_W-1:0]};
        burst_bytes = (remaining_q < room) ? remaining_q[31:0] : room[31:0];
        burst_words = burst_bytes[CW+BEAT_SHIFT-1:BEAT_SHIFT];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake outputs and datapath strobes.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        load_cmd   = 1'b0;
        cmd_accept = 1'b0;
        burst_end  = 1'b0;
        cmd_valid  = 1'b0;
        data_valid = 1'b0;
        data_last  = 1'b0;
        pop        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.x_data_send_back_start) begin
                    load_cmd = 1'b1;
                    state_d  = (rounded_len == '0) ? S_DONE : S_CMD;
                end
            end
            S_CMD: begin
                busy      = 1'b1;
                // Count cannot drop while here, so valid stays up once raised.
                cmd_valid = (count >= burst_words);
                if (cmd_valid && bus.wr_cmd_ready) begin
                    cmd_accept = 1'b1;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                busy       = 1'b1;
                data_valid = !fifo_empty;
                data_last  = data_valid && (beats_q == ONE_BEAT_C);
                pop        = data_valid && bus.wr_data_ready;
                if (pop && data_last) begin
                    burst_end = 1'b1;
                    state_d   = (remaining_q == {1'b0, burst_q}) ? S_DONE : S_CMD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Transfer address, remaining bytes and per-burst beat tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            burst_q     <= '0;
            beats_q     <= '0;
        end else begin
            if (load_cmd) begin
                addr_q      <= bus.x_data_send_back_addr;
                remaining_q <= rounded_len;
            end else if (burst_end) begin
                addr_q      <= addr_q + {32'b0, burst_q};
                remaining_q <= remaining_q - {1'b0, burst_q};
            end
            if (cmd_accept) begin
                burst_q <= burst_bytes;
                beats_q <= burst_words;
            end else if (pop) begin
                beats_q <= beats_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status: sticky errors and accepted-beat counter
    // ------------------------------------------------------------------
    logic [1:0]  error_q;
    logic [31:0] beat_count_q;

    // Sticky error flags: dropped word, and start while a command is active
    // (the DONE cycle still counts as active).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            error_q <= 2'b00;
        end else begin
            if (bus.x_data_out_valid && fifo_full) begin
                error_q[0] <= 1'b1;
            end
            if (bus.x_data_send_back_start && (state_q != S_IDLE)) begin
                error_q[1] <= 1'b1;
            end
        end
    end

    // Free-running count of beats accepted on the write data port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_count_q <= '0;
        end else if (pop) begin
            beat_count_q <= beat_count_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs; command and data fields are zero while not presented
    // ------------------------------------------------------------------
    assign bus.x_data_out_almost_full   = almost_full_q;
    assign bus.wr_cmd_valid             = cmd_valid;
    assign bus.wr_cmd_addr              = cmd_valid ? addr_q : '0;
    assign bus.wr_cmd_len               = cmd_valid ? burst_bytes : '0;
    assign bus.wr_data_valid            = data_valid;
    assign bus.wr_data                  = data_valid ? mem[rd_ptr] : '0;
    assign bus.wr_data_last             = data_last;
    assign bus.wr_busy                  = busy;
    assign bus.wr_done                  = done;
    assign bus.wr_error                 = error_q;
    assign bus.state_counters_x_host_wr = beat_count_q;

endmodule

// File: tb/tb_sgd_x_host_wr_burst.sv
// Scoreboard bench for sgd_x_host_wr_burst: directed stimulus pushes the
// expected commands, beats and done pulses into queues; a negedge monitor
// pops and compares whenever the DUT presents a handshake or a done pulse.
module tb_sgd_x_host_wr_burst;

    typedef struct {
        logic [511:0] data;
        logic         last;
    } beat_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sgd_x_host_wr_burst_if #(.DATA_WIDTH(512)) bus ();

    sgd_x_host_wr_burst dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    checks      = 0;
    int    failures    = 0;
    int    cyc         = 0;
    int    done_seen   = 0;
    int    done_target = 0;
    int    occ         = 0;
    int    last_hs_cyc = 0;
    bit    t3_run      = 1'b0;

    cmd_t  exp_cmd[$];
    beat_t exp_data[$];
    bit    exp_done_lat[$];

    cmd_t  mon_c;
    beat_t mon_b;
    bit    mon_lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT handshake / done pulse against the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            occ = 0;
        end else begin
            if (bus.wr_cmd_valid && bus.wr_cmd_ready) begin
                check("cmd_expected", 512'(exp_cmd.size() != 0), 512'(1));
                if (exp_cmd.size() != 0) begin
                    mon_c = exp_cmd.pop_front();
                    check("cmd_addr", bus.wr_cmd_addr, mon_c.addr);
                    check("cmd_len", bus.wr_cmd_len, mon_c.len);
                    check("cmd_fully_buffered", 512'(occ >= int'(mon_c.len / 64)), 512'(1));
                end
            end
            if (bus.wr_data_valid && bus.wr_data_ready) begin
                check("data_expected", 512'(exp_data.size() != 0), 512'(1));
                if (exp_data.size() != 0) begin
                    mon_b = exp_data.pop_front();
                    check("wr_data", bus.wr_data, mon_b.data);
                    check("wr_data_last", bus.wr_data_last, mon_b.last);
                end
                if (bus.wr_data_last) last_hs_cyc = cyc;
                occ--;
            end
            if (bus.x_data_out_valid && occ < 128) occ++;
            if (bus.wr_done) begin
                done_seen++;
                check("done_expected", 512'(exp_done_lat.size() != 0), 512'(1));
                check("busy_low_at_done", bus.wr_busy, 0);
                if (exp_done_lat.size() != 0) begin
                    mon_lat = exp_done_lat.pop_front();
                    if (mon_lat) check("done_latency", cyc, last_hs_cyc + 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mk_word(input int tag, input int idx);
        logic [15:0] t;
        logic [15:0] i;
        t = tag[15:0];
        i = idx[15:0];
        return {16{t, i}};
    endfunction

    task automatic push_word(input logic [511:0] d, input bit track, input bit last);
        beat_t b;
        bus.x_data_out       = d;
        bus.x_data_out_valid = 1'b1;
        if (track) begin
            b.data = d;
            b.last = last;
            exp_data.push_back(b);
        end
        tick();
        bus.x_data_out_valid = 1'b0;
    endtask

    task automatic start_cmd(input logic [63:0] addr, input logic [31:0] len);
        bus.x_data_send_back_addr   = addr;
        bus.x_data_send_back_length = len;
        bus.x_data_send_back_start  = 1'b1;
        tick();
        bus.x_data_send_back_start  = 1'b0;
    endtask

    task automatic expect_cmd(input logic [63:0] addr, input logic [31:0] len);
        cmd_t c;
        c.addr = addr;
        c.len  = len;
        exp_cmd.push_back(c);
    endtask

    task automatic expect_done(input bit check_latency);
        exp_done_lat.push_back(check_latency);
        done_target++;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_seen < done_target && n < 3000) begin
            tick();
            n++;
        end
        check("done_count", done_seen, done_target);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_cmd_valid"},   bus.wr_cmd_valid, 0);
        check({tag, "_cmd_addr"},    bus.wr_cmd_addr, 0);
        check({tag, "_cmd_len"},     bus.wr_cmd_len, 0);
        check({tag, "_data_valid"},  bus.wr_data_valid, 0);
        check({tag, "_data"},        bus.wr_data, 0);
        check({tag, "_data_last"},   bus.wr_data_last, 0);
        check({tag, "_busy"},        bus.wr_busy, 0);
        check({tag, "_done"},        bus.wr_done, 0);
        check({tag, "_almost_full"}, bus.x_data_out_almost_full, 0);
        check({tag, "_error"},       bus.wr_error, 0);
        check({tag, "_counter"},     bus.state_counters_x_host_wr, 0);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        tick();
        check_zero_outputs(tag);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.x_data_send_back_start  = 1'b0;
        bus.x_data_send_back_addr   = '0;
        bus.x_data_send_back_length = '0;
        bus.x_data_out              = '0;
        bus.x_data_out_valid        = 1'b0;
        bus.wr_cmd_ready            = 1'b1;
        bus.wr_data_ready           = 1'b1;

        tick();
        apply_reset("reset");

        // T1: aligned 256-byte transfer, data buffered before the command
        expect_cmd(64'h1000, 32'd256);
        for (int i = 0; i < 4; i++) push_word(mk_word(1, i), 1'b1, i == 3);
        expect_done(1'b1);
        start_cmd(64'h1000, 32'd256);
        wait_done();
        check("t1_counter", bus.state_counters_x_host_wr, 4);

        // T2: transfer straddling a 4 KiB boundary splits into 64 + 192
        expect_cmd(64'h0FC0, 32'd64);
        expect_cmd(64'h1000, 32'd192);
        for (int i = 0; i < 4; i++) push_word(mk_word(2, i), 1'b1, (i == 0) || (i == 3));
        expect_done(1'b1);
        start_cmd(64'h0FC0, 32'd256);
        wait_done();
        check("t2_counter", bus.state_counters_x_host_wr, 8);

        // T3: 8 KiB streamed behind the command, write data ready toggling
        expect_cmd(64'h0, 32'd4096);
        expect_cmd(64'h1000, 32'd4096);
        expect_done(1'b1);
        start_cmd(64'h0, 32'd8192);
        t3_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 128; i++) begin
                    int n = 0;
                    while (bus.x_data_out_almost_full && n < 1000) begin
                        tick();
                        n++;
                    end
                    push_word(mk_word(3, i), 1'b1, (i % 64) == 63);
                end
                wait_done();
                t3_run = 1'b0;
            end
            begin
                int n = 0;
                while (t3_run && n < 5000) begin
                    bus.wr_data_ready = ~bus.wr_data_ready;
                    tick();
                    n++;
                end
            end
        join
        bus.wr_data_ready = 1'b1;
        check("t3_counter", bus.state_counters_x_host_wr, 136);

        // T5a: zero-length command completes with a bare done pulse
        expect_done(1'b0);
        start_cmd(64'h5000, 32'd0);
        check("t5_len0_done", bus.wr_done, 1);
        check("t5_len0_busy", bus.wr_busy, 0);
        tick();
        check("t5_len0_done_single", bus.wr_done, 0);
        wait_done();

        // T5b: second start while busy is ignored and flagged
        expect_cmd(64'h2000, 32'd128);
        expect_done(1'b1);
        start_cmd(64'h2000, 32'd128);
        start_cmd(64'h6000, 32'd512);
        check("t5_busy_error", bus.wr_error, 2'b10);
        for (int i = 0; i < 2; i++) push_word(mk_word(5, i), 1'b1, i == 1);
        wait_done();
        check("t5_counter", bus.state_counters_x_host_wr, 138);

        // T4: almost-full timing and overflow with no command running
        apply_reset("reset2");
        bus.wr_cmd_ready = 1'b0;
        for (int i = 0; i < 119; i++) push_word(mk_word(4, i), 1'b0, 1'b0);
        push_word(mk_word(4, 119), 1'b0, 1'b0);
        check("t4_af_lag", bus.x_data_out_almost_full, 0);
        tick();
        check("t4_af_set", bus.x_data_out_almost_full, 1);
        for (int i = 120; i < 128; i++) push_word(mk_word(4, i), 1'b0, 1'b0);
        check("t4_full_no_error", bus.wr_error, 2'b00);
        push_word(mk_word(4, 128), 1'b0, 1'b0);
        check("t4_overflow_error", bus.wr_error, 2'b01);

        // T6: reset in the middle of a data phase, then a fresh transfer
        apply_reset("reset3");
        bus.wr_cmd_ready  = 1'b1;
        bus.wr_data_ready = 1'b0;
        expect_cmd(64'h3000, 32'd256);
        for (int i = 0; i < 4; i++) push_word(mk_word(6, i), 1'b0, 1'b0);
        start_cmd(64'h3000, 32'd256);
        begin
            int n = 0;
            while (!bus.wr_data_valid && n < 50) begin
                tick();
                n++;
            end
        end
        check("t6_in_data", bus.wr_data_valid, 1);
        rst_n = 1'b0;
        tick();
        check_zero_outputs("midreset");
        rst_n = 1'b1;
        bus.wr_data_ready = 1'b1;
        expect_cmd(64'h4000, 32'd128);
        for (int i = 0; i < 2; i++) push_word(mk_word(7, i), 1'b1, i == 1);
        expect_done(1'b1);
        start_cmd(64'h4000, 32'd100);
        wait_done();
        check("t6_counter", bus.state_counters_x_host_wr, 2);

        repeat (3) tick();
        check("cmd_queue_drained", exp_cmd.size(), 0);
        check("data_queue_drained", exp_data.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
